// File: rtl/pipe_stage_skid.sv
// Pipeline stage with a registered output. SKID_EN=1 gives a two-entry skid buffer with
// registered in_ready. SKID_EN=0 gives a single register whose ready passes straight through.
module pipe_stage_skid #(
  parameter int DATA_W  = 32,
  parameter int CTRL_W  = 16,
  parameter int SKID_EN = 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              clr,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [CTRL_W-1:0] in_ctrl,
  input  logic [DATA_W-1:0] in_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [CTRL_W-1:0] out_ctrl,
  output logic [DATA_W-1:0] out_data,
  output logic [1:0]        count
);

  typedef enum logic [1:0] {
    StEmpty = 2'd0,
    StOne   = 2'd1,
    StFull  = 2'd2
  } state_e;

  state_e            state_q;
  logic              main_valid_q;
  logic [CTRL_W-1:0] main_ctrl_q;
  logic [DATA_W-1:0] main_data_q;
  logic              skid_valid_q;
  logic [CTRL_W-1:0] skid_ctrl_q;
  logic [DATA_W-1:0] skid_data_q;

  logic in_fire;
  logic out_fire;

  // Skid mode takes ready from the skid flag alone, so out_ready never reaches in_ready.
  assign in_ready = (SKID_EN != 0) ? !skid_valid_q : (!main_valid_q || out_ready);
  assign in_fire  = in_valid && in_ready;
  assign out_fire = main_valid_q && out_ready;

  // The outputs come straight from the main entry. The payload is kept at zero while it is
  // empty, so a bubble is a NOP.
  assign out_valid = main_valid_q;
  assign out_ctrl  = main_ctrl_q;
  assign out_data  = main_data_q;
  assign count     = state_q;

  // State and payload update. Reset has the highest priority, then clr, then the handshakes.
  always_ff @(posedge clk) begin
    if (reset || clr) begin
      state_q      <= StEmpty;
      main_valid_q <= 1'b0;
      main_ctrl_q  <= '0;
      main_data_q  <= '0;
      skid_valid_q <= 1'b0;
      skid_ctrl_q  <= '0;
      skid_data_q  <= '0;
    end else if (SKID_EN != 0) begin
      unique case (state_q)
        StEmpty: begin
          if (in_fire) begin
            main_valid_q <= 1'b1;
            main_ctrl_q  <= in_ctrl;
            main_data_q  <= in_data;
            state_q      <= StOne;
          end
        end
        StOne: begin
          if (in_fire && out_fire) begin
            main_ctrl_q <= in_ctrl;
            main_data_q <= in_data;
          end else if (in_fire) begin
            skid_valid_q <= 1'b1;
            skid_ctrl_q  <= in_ctrl;
            skid_data_q  <= in_data;
            state_q      <= StFull;
          end else if (out_fire) begin
            main_valid_q <= 1'b0;
            main_ctrl_q  <= '0;
            main_data_q  <= '0;
            state_q      <= StEmpty;
          end
        end
        StFull: begin
          // in_ready is low here, so only the downstream side can move.
          if (out_fire) begin
            main_ctrl_q  <= skid_ctrl_q;
            main_data_q  <= skid_data_q;
            skid_valid_q <= 1'b0;
            skid_ctrl_q  <= '0;
            skid_data_q  <= '0;
            state_q      <= StOne;
          end
        end
        default: begin
          state_q <= StEmpty;
        end
      endcase
    end else begin
      if (in_fire) begin
        main_valid_q <= 1'b1;
        main_ctrl_q  <= in_ctrl;
        main_data_q  <= in_data;
        state_q      <= StOne;
      end else if (out_fire) begin
        main_valid_q <= 1'b0;
        main_ctrl_q  <= '0;
        main_data_q  <= '0;
        state_q      <= StEmpty;
      end
    end
  end

endmodule

// File: tb/tb_pipe_stage_skid.sv
// Bench for pipe_stage_skid. The skid-buffer and single-register variants run side by side
// on the same stimulus, and each one is checked against a FIFO scoreboard of its own.
module tb_pipe_stage_skid;

  logic        clk = 1'b0;
  logic        reset;
  logic        clr;
  logic        in_valid;
  logic [15:0] in_ctrl;
  logic [31:0] in_data;
  logic        out_ready;

  logic        s_in_ready, s_out_valid;
  logic [15:0] s_out_ctrl;
  logic [31:0] s_out_data;
  logic [1:0]  s_count;

  logic        r_in_ready, r_out_valid;
  logic [15:0] r_out_ctrl;
  logic [31:0] r_out_data;
  logic [1:0]  r_count;

  int checks   = 0;
  int failures = 0;

  // Scoreboard entries are {ctrl, data}.
  logic [47:0] sq[$];
  logic [47:0] rq[$];

  always #5 clk = ~clk;

  pipe_stage_skid #(.DATA_W(32), .CTRL_W(16), .SKID_EN(1)) u_skid (
    .clk       (clk),
    .reset     (reset),
    .clr       (clr),
    .in_valid  (in_valid),
    .in_ready  (s_in_ready),
    .in_ctrl   (in_ctrl),
    .in_data   (in_data),
    .out_valid (s_out_valid),
    .out_ready (out_ready),
    .out_ctrl  (s_out_ctrl),
    .out_data  (s_out_data),
    .count     (s_count)
  );

  pipe_stage_skid #(.DATA_W(32), .CTRL_W(16), .SKID_EN(0)) u_reg (
    .clk       (clk),
    .reset     (reset),
    .clr       (clr),
    .in_valid  (in_valid),
    .in_ready  (r_in_ready),
    .in_ctrl   (in_ctrl),
    .in_data   (in_data),
    .out_valid (r_out_valid),
    .out_ready (out_ready),
    .out_ctrl  (r_out_ctrl),
    .out_data  (r_out_data),
    .count     (r_count)
  );

  task automatic chk(input string tag, input logic [47:0] obs, input logic [47:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Called at posedge+1. It drives one cycle of inputs and checks both DUTs against their
  // models, then advances past the edge and updates the models.
  task automatic cycle(input logic iv, input logic [31:0] d, input logic ordy, input logic cl);
    logic        s_rdy, r_rdy, s_fin, s_fout, r_fin, r_fout;
    logic [47:0] s_head, r_head;
    in_valid  = iv;
    in_data   = d;
    in_ctrl   = d[15:0] ^ 16'h5A3C;
    out_ready = ordy;
    clr       = cl;
    #1;
    s_rdy  = (sq.size() < 2);
    r_rdy  = (rq.size() == 0) || ordy;
    s_head = (sq.size() > 0) ? sq[0] : 48'd0;
    r_head = (rq.size() > 0) ? rq[0] : 48'd0;
    chk("skid in_ready",  48'(s_in_ready), 48'(s_rdy));
    chk("skid out_valid", 48'(s_out_valid), 48'(sq.size() > 0));
    chk("skid payload",   {s_out_ctrl, s_out_data}, s_head);
    chk("skid count",     48'(s_count), 48'(sq.size()));
    chk("reg in_ready",   48'(r_in_ready), 48'(r_rdy));
    chk("reg out_valid",  48'(r_out_valid), 48'(rq.size() > 0));
    chk("reg payload",    {r_out_ctrl, r_out_data}, r_head);
    chk("reg count",      48'(r_count), 48'(rq.size()));
    s_fin  = iv && s_rdy;
    s_fout = ordy && (sq.size() > 0);
    r_fin  = iv && r_rdy;
    r_fout = ordy && (rq.size() > 0);
    @(posedge clk);
    #1;
    if (cl) begin
      sq.delete();
      rq.delete();
    end else begin
      if (s_fout) void'(sq.pop_front());
      if (s_fin) sq.push_back({in_ctrl, in_data});
      if (r_fout) void'(rq.pop_front());
      if (r_fin) rq.push_back({in_ctrl, in_data});
    end
  endtask

  // Reset is applied with every other input active, so that it is seen to win over them.
  task automatic do_reset();
    reset     = 1'b1;
    in_valid  = 1'b1;
    in_data   = 32'h99;
    in_ctrl   = 16'h1234;
    out_ready = 1'b1;
    clr       = 1'b1;
    @(posedge clk);
    #1;
    reset = 1'b0;
    sq.delete();
    rq.delete();
  endtask

  initial begin
    reset = 1'b1; clr = 1'b0; in_valid = 1'b0; in_ctrl = '0; in_data = '0; out_ready = 1'b0;
    @(posedge clk);
    #1;
    do_reset();
    // Reset state, with in_ready high in both modes.
    cycle(1'b0, 32'h0, 1'b1, 1'b0);

    // Streaming: in ONE, a push and a pop in the same cycle keep count at 1.
    cycle(1'b1, 32'h1, 1'b1, 1'b0);
    cycle(1'b1, 32'h2, 1'b1, 1'b0);
    cycle(1'b1, 32'h3, 1'b1, 1'b0);
    cycle(1'b1, 32'h4, 1'b1, 1'b0);
    cycle(1'b0, 32'h0, 1'b1, 1'b0);
    cycle(1'b0, 32'h0, 1'b1, 1'b0);

    // Back-pressure: fill to FULL, hold C at the input, then release in order.
    cycle(1'b1, 32'hA, 1'b0, 1'b0);
    cycle(1'b1, 32'hB, 1'b0, 1'b0);
    cycle(1'b1, 32'hC, 1'b0, 1'b0);
    cycle(1'b1, 32'hC, 1'b0, 1'b0);
    cycle(1'b1, 32'hC, 1'b1, 1'b0);
    cycle(1'b1, 32'hC, 1'b1, 1'b0);
    cycle(1'b0, 32'h0, 1'b1, 1'b0);
    cycle(1'b0, 32'h0, 1'b1, 1'b0);

    // Flush while FULL, with 0x55 offered in the same cycle.
    cycle(1'b1, 32'h11, 1'b0, 1'b0);
    cycle(1'b1, 32'h22, 1'b0, 1'b0);
    cycle(1'b1, 32'h55, 1'b0, 1'b1);
    cycle(1'b0, 32'h0, 1'b1, 1'b0);
    cycle(1'b0, 32'h0, 1'b1, 1'b0);
    // Flush while the downstream side takes an entry.
    cycle(1'b1, 32'h33, 1'b1, 1'b0);
    cycle(1'b1, 32'h44, 1'b1, 1'b1);
    cycle(1'b0, 32'h0, 1'b1, 1'b0);

    // out_ready toggles under continuous input, which exercises the single-register mode.
    cycle(1'b1, 32'h61, 1'b1, 1'b0);
    cycle(1'b1, 32'h62, 1'b0, 1'b0);
    cycle(1'b1, 32'h63, 1'b1, 1'b0);
    cycle(1'b1, 32'h64, 1'b0, 1'b0);
    cycle(1'b1, 32'h65, 1'b1, 1'b0);
    cycle(1'b0, 32'h0, 1'b1, 1'b0);
    cycle(1'b0, 32'h0, 1'b1, 1'b0);
    cycle(1'b0, 32'h0, 1'b1, 1'b0);

    // Reset while FULL, followed by a push that takes the one-cycle latency.
    cycle(1'b1, 32'h81, 1'b0, 1'b0);
    cycle(1'b1, 32'h82, 1'b0, 1'b0);
    do_reset();
    cycle(1'b1, 32'h7, 1'b1, 1'b0);
    cycle(1'b0, 32'h0, 1'b1, 1'b0);
    cycle(1'b0, 32'h0, 1'b1, 1'b0);

    // Mixed traffic with an occasional flush.
    for (int i = 0; i < 60; i++) begin
      cycle(1'($urandom_range(0, 1)), $urandom, 1'($urandom_range(0, 1)),
            ($urandom_range(0, 19) == 0));
    end
    cycle(1'b0, 32'h0, 1'b1, 1'b0);
    cycle(1'b0, 32'h0, 1'b1, 1'b0);
    cycle(1'b0, 32'h0, 1'b1, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/pipe_stage_skid.md
PIPE_STAGE_SKID -- requirements
Module: pipe_stage_skid

Interface
REQ-001 SHALL have parameter DATA_W, default 32: width of the data payload (PC, operands, immediates).
REQ-002 SHALL have parameter CTRL_W, default 16: width of the control payload (write enables, mux selects, ALU/branch ops).
REQ-003 SHALL have parameter SKID_EN, default 1: 1 selects the two-entry skid buffer; 0 selects a single register with pass-through ready.
REQ-004 SHALL have port clk, input, 1 bit: the single clock; all state updates occur on its rising edge.
REQ-005 SHALL have port reset, input, 1 bit: reset is synchronous and active-high.
REQ-006 SHALL have port clr, input, 1 bit: flush; discards all held entries.
REQ-007 SHALL have port in_valid, input, 1 bit: the upstream stage presents an entry.
REQ-008 SHALL have port in_ready, output, 1 bit: the stage accepts an entry this cycle.
REQ-009 SHALL have port in_ctrl, input, CTRL_W bits: incoming control payload.
REQ-010 SHALL have port in_data, input, DATA_W bits: incoming data payload.
REQ-011 SHALL have port out_valid, output, 1 bit: the stage presents an entry downstream.
REQ-012 SHALL have port out_ready, input, 1 bit: the downstream stage accepts the entry.
REQ-013 SHALL have port out_ctrl, output, CTRL_W bits: outgoing control payload.
REQ-014 SHALL have port out_data, output, DATA_W bits: outgoing data payload.
REQ-015 SHALL have port count, output, 2 bits: the number of entries held (0..2; 0..1 when SKID_EN=0).

Function
REQ-016 SHALL define in_fire = in_valid & in_ready and out_fire = out_valid & out_ready; a transfer occurs only on a fire.
REQ-017 SHALL drive out_valid, out_ctrl and out_data directly from registers (main entry), with no combinational path from in_* ports.
REQ-018 SHALL drive out_ctrl and out_data to all-zero whenever out_valid=0, so that a bubble is a NOP.
REQ-019 SHALL have a latency of 1 cycle: an entry accepted into an empty stage appears on out_* in the next cycle.
REQ-020 SHALL, when SKID_EN=1, drive in_ready = !skid_valid from registered state only, with no combinational path from out_ready.
REQ-021 SHALL, when SKID_EN=1, use states EMPTY (count=0), ONE (main valid; count=1) and FULL (main and skid valid; count=2).
REQ-022 SHALL, in EMPTY on in_fire, load main from in_* and move to ONE.
REQ-023 SHALL, in ONE, apply these transitions: on in_fire and out_fire, load main from in_* and stay in ONE; on in_fire without out_fire, load skid from in_* and move to FULL; on out_fire without in_fire, clear main and move to EMPTY.
REQ-024 SHALL, in FULL, hold in_ready=0 and, on out_fire, move skid into main, clear skid and move to ONE.
REQ-025 SHALL, when SKID_EN=0, hold a single entry with in_ready = !out_valid | out_ready (combinational), with count in 0..1.
REQ-026 SHALL preserve strict FIFO order, with no entry duplicated or lost except by clr or reset.
REQ-027 SHALL, on clr=1, make count=0 and out_valid=0 and zero all payload registers in the next cycle.
REQ-028 SHALL give clr priority over a simultaneous in_fire or out_fire: the entry offered with clr is discarded, and out_fire in the clr cycle completes normally downstream.
REQ-029 SHALL hold all state unchanged while in_fire=0 and out_fire=0, including when out_ready=0 in FULL.

Reset
REQ-030 SHALL, on reset=1 at a rising clk edge, set out_valid=0, out_ctrl=0, out_data=0 and count=0, and clear skid_valid.
REQ-031 SHALL have in_ready=1 in the cycle after reset, in both SKID_EN modes.
REQ-032 SHALL give reset priority over clr and over all handshakes, including reset asserted mid-operation while FULL.

Verification
REQ-033 SHALL cover streaming: SKID_EN=1, out_ready=1, in_data=1,2,3,4 on consecutive cycles -> out_data=1,2,3,4 one cycle later each, count=1, in_ready=1 throughout.
REQ-034 SHALL cover back-pressure: out_ready=0, push A=0xA then B=0xB -> count=2, in_ready=0, out_data=0xA; C held at the input is not accepted; then out_ready=1 -> out_data=0xA, 0xB, C in order.
REQ-035 SHALL cover flush: state FULL with clr=1 and in_valid=1 (data 0x55) -> next cycle count=0, out_valid=0, out_ctrl=0, out_data=0, and 0x55 never appears.
REQ-036 SHALL cover single-register mode: SKID_EN=0 with out_ready toggling 1,0,1 and continuous input -> in_ready equals !out_valid|out_ready each cycle, count never exceeds 1, and order is preserved.
REQ-037 SHALL cover reset mid-operation: state FULL with reset=1 for one cycle -> count=0, out_valid=0, payloads 0, in_ready=1; a subsequent push of 0x7 appears after 1 cycle.
REQ-038 SHALL cover simultaneous events in ONE: in_fire and out_fire in the same cycle -> count stays 1 and out_data is the new entry on the next cycle.
